// File: rtl/map_scanner.sv
`default_nettype none
// ============================================================================
// Module   : map_scanner
// Brief    : Walks the map row-major, streams each cell to a drawer over a
//            valid/ready handshake and counts pellet cells (codes 2 and 3).
//            Optional: define MAP_SCANNER_SKIP_EMPTY_EN to drop code-0 cells.
// Revision : 1.0 - initial release
// ============================================================================
module map_scanner #(
    parameter int MAP_WIDTH  = 20,
    parameter int MAP_HEIGHT = 21
) (
    input  logic       clock_50,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] map_x,
    output logic [4:0] map_y,
    output logic       readwrite,
    output logic [2:0] sprite_data_out,
    input  logic [2:0] sprite_data_in,
    output logic [4:0] cell_x,
    output logic [4:0] cell_y,
    output logic [2:0] cell_sprite,
    output logic       cell_valid,
    input  logic       cell_ready,
    output logic [8:0] pellet_count
);

    localparam logic [4:0] c_LAST_X = 5'(MAP_WIDTH - 1);
    localparam logic [4:0] c_LAST_Y = 5'(MAP_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_READ = 3'd2,
        S_EMIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t     r_state;
    logic [8:0] r_pellets;

    logic       w_last_x;
    logic       w_last_cell;
    logic       w_pellet;
    logic [4:0] w_next_x;
    logic [4:0] w_next_y;

    assign readwrite       = 1'b0;
    assign sprite_data_out = 3'b000;

    // map_x/map_y double as the traversal coordinate counters
    always_comb begin
        w_last_x    = (map_x == c_LAST_X);
        w_last_cell = w_last_x && (map_y == c_LAST_Y);
        w_next_x    = w_last_x ? 5'd0 : map_x + 5'd1;
        w_next_y    = w_last_x ? map_y + 5'd1 : map_y;
        w_pellet    = (sprite_data_in == 3'd2) || (sprite_data_in == 3'd3);
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pellets    <= 9'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            map_x        <= 5'd0;
            map_y        <= 5'd0;
            cell_x       <= 5'd0;
            cell_y       <= 5'd0;
            cell_sprite  <= 3'd0;
            cell_valid   <= 1'b0;
            pellet_count <= 9'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        map_x     <= 5'd0;
                        map_y     <= 5'd0;
                        r_pellets <= 9'd0;
                        busy      <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_state <= S_READ;
                end
                S_READ: begin
                    cell_x      <= map_x;
                    cell_y      <= map_y;
                    cell_sprite <= sprite_data_in;
                    // saturate rather than wrap on a fully pellet-filled 512-cell map
                    if (w_pellet && (r_pellets != 9'h1FF)) begin
                        r_pellets <= r_pellets + 9'd1;
                    end
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
                    if (sprite_data_in == 3'd0) begin
                        if (w_last_cell) begin
                            done         <= 1'b1;
                            pellet_count <= r_pellets;
                            r_state      <= S_FIN;
                        end else begin
                            map_x   <= w_next_x;
                            map_y   <= w_next_y;
                            r_state <= S_ADDR;
                        end
                    end else begin
                        cell_valid <= 1'b1;
                        r_state    <= S_EMIT;
                    end
`else
                    cell_valid <= 1'b1;
                    r_state    <= S_EMIT;
`endif
                end
                S_EMIT: begin
                    if (cell_ready) begin
                        cell_valid <= 1'b0;
                        if (w_last_cell) begin
                            done         <= 1'b1;
                            pellet_count <= r_pellets;
                            r_state      <= S_FIN;
                        end else begin
                            map_x   <= w_next_x;
                            map_y   <= w_next_y;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy       <= 1'b0;
                    cell_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_map_scanner
// Brief    : Randomized self-checking bench for map_scanner with a row-major
//            reference model of the expected cell stream, pellet count and timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_scanner;

    localparam int W = 20;
    localparam int H = 21;
    localparam int N = W * H;

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start    = 1'b0;
    logic       cell_ready = 1'b0;
    logic [2:0] sprite_data_in = 3'd0;
    logic       busy, done, readwrite, cell_valid;
    logic [4:0] map_x, map_y, cell_x, cell_y;
    logic [2:0] sprite_data_out, cell_sprite;
    logic [8:0] pellet_count;

    map_scanner #(.MAP_WIDTH(W), .MAP_HEIGHT(H)) dut (
        .clock_50        (clock_50),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .map_x           (map_x),
        .map_y           (map_y),
        .readwrite       (readwrite),
        .sprite_data_out (sprite_data_out),
        .sprite_data_in  (sprite_data_in),
        .cell_x          (cell_x),
        .cell_y          (cell_y),
        .cell_sprite     (cell_sprite),
        .cell_valid      (cell_valid),
        .cell_ready      (cell_ready),
        .pellet_count    (pellet_count)
    );

    always #5 clock_50 = ~clock_50;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] s;
    } cell_t;

    int         checks = 0;
    int         failures = 0;
    logic [2:0] mem [N];
    cell_t      exp_q [$];
    int         exp_pellets = 0;
    int         exp_cycles = 0;
    int         edge_cnt = 0;
    int         start_edge = 0;
    int         last_done_cycle = 0;
    int         xfer_cnt = 0;
    int         done_pulses = 0;
    int         stall_cnt = 0;
    int         ready_mode = 0;
    bit         scanning = 1'b0;
    bit         check_timing = 1'b0;
    bit         prev_valid = 1'b0;
    bit         prev_xfer = 1'b0;
    bit         prev_done = 1'b0;
    logic [12:0] prev_cell = '0;
    logic [9:0]  prev_map = '0;
    logic [2:0]  sprite_53 = 3'd7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Expected stream derived straight from the map contents and traversal rules
    task automatic build_model();
        int emits, skips;
        exp_q.delete();
        exp_pellets = 0;
        emits = 0;
        skips = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                logic [2:0] s;
                s = mem[y * W + x];
                if (s == 3'd2 || s == 3'd3) exp_pellets++;
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
                if (s == 3'd0) begin
                    skips++;
                    continue;
                end
`endif
                exp_q.push_back(cell_t'{x: 5'(x), y: 5'(y), s: s});
                emits++;
            end
        end
        exp_cycles = 1 + 3 * emits + 2 * skips + 1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = 3'($urandom_range(0, 7));
    endtask

    task automatic fill_const(input logic [2:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    // Edge counter
    initial forever begin
        @(posedge clock_50);
        edge_cnt++;
    end

    // Map memory: address sampled on an edge, data valid one cycle later
    initial begin
        int a;
        forever begin
            @(posedge clock_50);
            a = int'(map_y) * W + int'(map_x);
            #1;
            if (a < N) sprite_data_in = mem[a];
            else sprite_data_in = 3'd0;
        end
    end

    // Downstream drawer
    initial forever begin
        @(posedge clock_50);
        #2;
        case (ready_mode)
            1: cell_ready = ($urandom_range(0, 9) < 7);
            2: begin
                if (cell_valid && cell_x == 5'd2 && cell_y == 5'd0 && stall_cnt < 10) begin
                    cell_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    cell_ready = 1'b1;
                end
            end
            default: cell_ready = 1'b1;
        endcase
    end

    // Compare process
    initial forever begin
        @(negedge clock_50);
        if (done) begin
            done_pulses++;
            check("done_one_cycle_prev", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
        if (scanning) begin
            check("busy_in_scan", {31'd0, busy}, 32'd1);
            if (prev_valid && !prev_xfer)
                check("emit_hold", {cell_valid, cell_x, cell_y, cell_sprite, map_x, map_y},
                      {1'b1, prev_cell, prev_map});
            if (cell_valid && cell_ready) begin
                xfer_cnt++;
                if (cell_x == 5'd5 && cell_y == 5'd3) sprite_53 = cell_sprite;
                if (exp_q.size() == 0) begin
                    check("extra_transfer", {cell_x, cell_y, cell_sprite}, 32'h7FFFFFFF);
                end else begin
                    cell_t e;
                    e = exp_q.pop_front();
                    check("transfer_xy_sprite", {cell_x, cell_y, cell_sprite}, e);
                end
            end
            if (done) begin
                check("done_all_cells", exp_q.size(), 0);
                check("pellet_count", pellet_count, exp_pellets);
                last_done_cycle = edge_cnt - start_edge + 2;
                if (check_timing) check("done_cycle", last_done_cycle, exp_cycles);
                scanning = 1'b0;
            end
            prev_valid = cell_valid;
            prev_xfer  = cell_valid && cell_ready;
            prev_cell  = {cell_x, cell_y, cell_sprite};
            prev_map   = {map_x, map_y};
        end
    end

    task automatic begin_scan(input bit timing);
        build_model();
        check_timing = timing;
        prev_valid = 1'b0;
        xfer_cnt = 0;
        @(posedge clock_50);
        #2 start = 1'b1;
        @(posedge clock_50);
        #1 start_edge = edge_cnt;
        #1 start = 1'b0;
        scanning = 1'b1;
    endtask

    task automatic run_scan(input bit timing);
        int budget;
        begin_scan(timing);
        budget = 0;
        while (scanning && budget < 8000) begin
            @(negedge clock_50);
            budget++;
        end
        checks++;
        if (scanning) begin
            failures++;
            $display("FAIL scan_timeout: no done after %0d cycles, required done", budget);
            scanning = 1'b0;
        end
        @(negedge clock_50);
        check("busy_after_fin", {31'd0, busy}, 32'd0);
        check("done_after_fin", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_cell(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clock_50);
            if (cell_valid && cell_x == 5'(x) && cell_y == 5'(y)) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_cell: cell (%0d,%0d) never offered, required within 5000 cycles", x, y);
        end
    endtask

    task automatic pulse_start_at(input int x, input int y);
        bit ok;
        wait_cell(x, y, ok);
        @(posedge clock_50);
        #2 start = 1'b1;
        @(posedge clock_50);
        #2 start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       {31'd0, busy}, 32'd0);
        check({tag, "_done"},       {31'd0, done}, 32'd0);
        check({tag, "_cell_valid"}, {31'd0, cell_valid}, 32'd0);
        check({tag, "_map_xy"},     {map_x, map_y}, 32'd0);
        check({tag, "_cell_xy"},    {cell_x, cell_y}, 32'd0);
        check({tag, "_cell_sprite"}, cell_sprite, 32'd0);
        check({tag, "_pellet_count"}, pellet_count, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0;

        repeat (3) @(posedge clock_50);
        #2;
        check_reset_outputs("reset");
        check("readwrite", {31'd0, readwrite}, 32'd0);
        check("sprite_data_out", sprite_data_out, 32'd0);
        reset_n = 1'b1;
        ready_mode = 0;

        // All cells code 1, drawer always ready
        fill_const(3'd1);
        run_scan(1'b1);
        check("A_transfers", xfer_cnt, 420);
        check("A_done_cycle", last_done_cycle, 1262);
        check("A_pellets", pellet_count, 0);

        // Two pellets at (5,3) and the final cell
        fill_const(3'd1);
        mem[3 * W + 5] = 3'd2;
        mem[20 * W + 19] = 3'd3;
        sprite_53 = 3'd7;
        run_scan(1'b1);
        check("B_pellets", pellet_count, 2);
        check("B_sprite_5_3", sprite_53, 2);

        // Drawer stalls 10 cycles on (2,0)
        fill_random();
        mem[2] = 3'd1;
        stall_cnt = 0;
        ready_mode = 2;
        run_scan(1'b0);
        check("C_stall_cycles", stall_cnt, 10);
        ready_mode = 0;

        // Second start mid-scan must be ignored
        fill_random();
        mem[4 * W + 7] = 3'd3;
        d0 = done_pulses;
        fork
            run_scan(1'b1);
            pulse_start_at(7, 4);
        join
        check("D_single_done", done_pulses - d0, 1);

        // Reset in the middle of a scan
        fill_random();
        mem[10 * W + 10] = 3'd2;
        d0 = done_pulses;
        begin_scan(1'b0);
        wait_cell(10, 10, ok);
        @(posedge clock_50);
        #3;
        scanning = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(posedge clock_50);
        check("E_no_done_on_reset", done_pulses - d0, 0);
        #2 reset_n = 1'b1;
        exp_q.delete();
        fill_random();
        ready_mode = 1;
        run_scan(1'b0);

        // Random maps with a random drawer
        repeat (3) begin
            fill_random();
            run_scan(1'b0);
        end
        ready_mode = 0;
        fill_random();
        run_scan(1'b1);

        // Sparse map: only (0,0) non-empty
        fill_const(3'd0);
        mem[0] = 3'd1;
        run_scan(1'b1);
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
        check("F_transfers", xfer_cnt, 1);
        check("F_done_cycle", last_done_cycle, 843);
`else
        check("F_transfers", xfer_cnt, 420);
        check("F_done_cycle", last_done_cycle, 1262);
`endif
        check("F_pellets", pellet_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/map_scanner.md
MAP_SCANNER -- requirements
Module: map_scanner

Interface
REQ-001 Parameter MAP_WIDTH, default 20, number of map columns; the legal range is 1..31.
REQ-002 Parameter MAP_HEIGHT, default 21, number of map rows; the legal range is 1..31 and MAP_WIDTH*MAP_HEIGHT SHALL NOT exceed 512.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clock_50 SHALL be an input, 1 bit, the system clock.
REQ-005 Port reset_n SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-006 Port start SHALL be an input, 1 bit, a single-cycle scan request.
REQ-007 Port busy SHALL be an output, 1 bit, high while a scan is in progress.
REQ-008 Port done SHALL be an output, 1 bit, a one-cycle pulse when a scan completes.
REQ-009 Port map_x SHALL be an output, 5 bits, the column address to the map controller.
REQ-010 Port map_y SHALL be an output, 5 bits, the row address to the map controller.
REQ-011 Port readwrite SHALL be an output, 1 bit, tied to 0 (read).
REQ-012 Port sprite_data_out SHALL be an output, 3 bits, tied to 3'b000.
REQ-013 Port sprite_data_in SHALL be an input, 3 bits, the map read data, which is valid one cycle after the address is sampled.
REQ-014 Port cell_x and cell_y SHALL be outputs, 5 bits each, the coordinates of the emitted cell.
REQ-015 Port cell_sprite SHALL be an output, 3 bits, the sprite code of the emitted cell.
REQ-016 Port cell_valid SHALL be an output, 1 bit, indicating that the emitted cell is valid.
REQ-017 Port cell_ready SHALL be an input, 1 bit, the downstream drawer's accept signal.
REQ-018 Port pellet_count SHALL be an output, 9 bits, the number of pellet cells (codes 2 and 3) found in the last completed scan.

Function
REQ-019 The FSM SHALL have the states IDLE, ADDR, READ, EMIT and FIN.
REQ-020 In IDLE, when start=1, the block SHALL clear the coordinate counters and the running pellet counter and go to ADDR; otherwise it SHALL stay in IDLE.
REQ-021 In ADDR, map_x/map_y SHALL present the current (x,y), and the next state SHALL be READ.
REQ-022 map_x/map_y SHALL remain stable throughout READ, and at the end of READ sprite_data_in SHALL be captured into cell_sprite, with cell_x/cell_y set to (x,y); the next state SHALL be EMIT.
REQ-023 In EMIT, cell_valid=1, and cell_x, cell_y and cell_sprite SHALL be held stable until cell_ready=1 is sampled; a transfer occurs on a clock edge where both are high.
REQ-024 On transfer, if x = MAP_WIDTH-1 and y = MAP_HEIGHT-1 the next state SHALL be FIN; otherwise the next state SHALL be ADDR with the next coordinate.
REQ-025 The traversal order SHALL be row-major: x increments first; at x = MAP_WIDTH-1, x wraps to 0 and y increments.
REQ-026 The running pellet counter SHALL increment by 1 when the captured code is 3'd2 or 3'd3, and SHALL NOT wrap (at most 512 cells).
REQ-027 FIN SHALL last one cycle: done=1, pellet_count is loaded from the running counter, and the next state is IDLE.
REQ-028 busy SHALL be 1 in ADDR, READ, EMIT and FIN, and 0 in IDLE.
REQ-029 start SHALL be ignored whenever busy=1.
REQ-030 cell_ready SHALL be ignored outside EMIT.
REQ-031 Minimum throughput SHALL be 3 cycles per cell when cell_ready is held at 1.
REQ-032 A full default scan with cell_ready=1 SHALL take 1 + 420*3 + 1 cycles from the start edge to done.

Reset
REQ-033 When reset_n=0, the block SHALL asynchronously go to IDLE, mid-scan included, and the scan SHALL be abandoned with no done pulse.
REQ-034 Reset values SHALL be: busy=0, done=0, cell_valid=0, map_x=0, map_y=0, cell_x=0, cell_y=0, cell_sprite=0, pellet_count=0, running counter=0.
REQ-035 The first start after reset release SHALL begin at (0,0).

Configuration
REQ-036 With MAP_SCANNER_SKIP_EMPTY_EN defined, cells whose captured code is 3'd0 SHALL bypass EMIT: READ SHALL go directly to the next ADDR (or to FIN after the last cell), and cell_valid SHALL never assert for code 0.
REQ-037 With MAP_SCANNER_SKIP_EMPTY_EN undefined, every cell including code 0 SHALL be emitted.

Verification
REQ-038 Map with all cells 3'd1, cell_ready=1, start pulsed -> 420 transfers in order (0,0),(1,0)..(19,0),(0,1)..(19,20), done at cycle 1262, pellet_count=0.
REQ-039 Map with cells (5,3)=2 and (19,20)=3, all others 1 -> pellet_count=2 after done; the transfer for (5,3) carries cell_sprite=2.
REQ-040 cell_ready held low for 10 cycles at cell (2,0) -> cell_valid stays high, cell_x=2 and cell_sprite stay stable, and no address advance occurs.
REQ-041 start pulsed again at cell (7,4) -> no effect; the scan continues and exactly one done pulse is produced.
REQ-042 reset_n asserted at cell (10,10), then released, then start pulsed -> all outputs at reset values, no done pulse, and the new scan starts at (0,0).
REQ-043 With MAP_SCANNER_SKIP_EMPTY_EN defined, a map all 0 except (0,0)=1 -> exactly one transfer, done at cycle 1 + 3 + 419*2 + 1.
